// File: rtl/cache_bus_arb_pkg.sv
// cache_bus_arb_pkg
// Shared definitions for the cache miss-path bus arbiter:
//   - arb_state_e : arbiter FSM states (idle, address phase, data phase)
//   - M_INST/M_DATA : master ids used by the owner/last registers and picker
//   - SZ_* : transfer size encodings carried on the *_size buses
package cache_bus_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_e;

  localparam logic M_INST = 1'b0;
  localparam logic M_DATA = 1'b1;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/cache_bus_arb_rr_pick2.sv
// rr_pick2
// Combinational two-way request picker.
// Ports:
//   req[1:0] : request vector, bit 0 = instruction master, bit 1 = data master
//   last     : id of the master served most recently
//   fair     : 1 = alternate on contention, 0 = data master always wins
//   gnt_id   : id of the picked master (M_INST when nobody requests)
module rr_pick2
  import cache_bus_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       fair,
  output logic       gnt_id
);

  // On contention the fair mode hands the bus to whoever was not served last;
  // with no requester the result is a don't-care, so inst is chosen.
  always_comb begin
    gnt_id = M_INST;
    case (req)
      2'b01:   gnt_id = M_INST;
      2'b10:   gnt_id = M_DATA;
      2'b11:   gnt_id = fair ? ~last : M_DATA;
      default: gnt_id = M_INST;
    endcase
  end

endmodule

// File: rtl/cache_bus_arb.sv
// cache_bus_arb
// Shares one SRAM-like memory port between the instruction-cache and
// data-cache miss paths. One transaction at a time, grant to data_ok.
// Ports:
//   clk, rst                 : clock, asynchronous active-low reset
//   cache_inst_* (in/out)    : instruction master request fields and handshakes
//   cache_data_* (in/out)    : data master request fields and handshakes
//   mem_* (out/in)           : forwarded request to the bridge and its responses
// Parameters:
//   ADDR_WIDTH, DATA_WIDTH   : bus widths
//   FAIR                     : 1 = round-robin on contention, 0 = data wins
module cache_bus_arb
  import cache_bus_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter bit FAIR       = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  cache_inst_req,
  input  logic                  cache_inst_wr,
  input  logic [1:0]            cache_inst_size,
  input  logic [ADDR_WIDTH-1:0] cache_inst_addr,
  input  logic [DATA_WIDTH-1:0] cache_inst_wdata,
  output logic [DATA_WIDTH-1:0] cache_inst_rdata,
  output logic                  cache_inst_addr_ok,
  output logic                  cache_inst_data_ok,

  input  logic                  cache_data_req,
  input  logic                  cache_data_wr,
  input  logic [1:0]            cache_data_size,
  input  logic [ADDR_WIDTH-1:0] cache_data_addr,
  input  logic [DATA_WIDTH-1:0] cache_data_wdata,
  output logic [DATA_WIDTH-1:0] cache_data_rdata,
  output logic                  cache_data_addr_ok,
  output logic                  cache_data_data_ok,

  output logic                  mem_req,
  output logic                  mem_wr,
  output logic [1:0]            mem_size,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_addr_ok,
  input  logic                  mem_data_ok
);

  arb_state_e state;
  arb_state_e state_next;
  logic       owner;
  logic       last;
  logic       pick;
  logic       sel;
  logic       sel_req;
  logic       any_req;
  logic       req_c;
  logic       addr_ok_c;
  logic       data_ok_c;

  rr_pick2 u_pick (
    .req    ({cache_data_req, cache_inst_req}),
    .last   (last),
    .fair   (FAIR),
    .gnt_id (pick)
  );

  assign any_req = cache_inst_req | cache_data_req;

  // In IDLE the bus follows the live pick; once granted it follows the owner.
  assign sel     = (state == ARB_IDLE) ? pick : owner;
  assign sel_req = sel ? cache_data_req : cache_inst_req;

  // Next state plus the raw request/handshake strobes for the selected master.
  always_comb begin
    state_next = state;
    req_c      = 1'b0;
    addr_ok_c  = 1'b0;
    data_ok_c  = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (any_req) begin
          req_c      = 1'b1;
          addr_ok_c  = mem_addr_ok;
          state_next = mem_addr_ok ? ARB_DATA : ARB_ADDR;
        end
      end
      ARB_ADDR: begin
        // A dropped request lowers mem_req but the grant is kept until addr_ok.
        req_c     = sel_req;
        addr_ok_c = mem_addr_ok;
        if (mem_addr_ok) state_next = ARB_DATA;
      end
      ARB_DATA: begin
        data_ok_c = mem_data_ok;
        if (mem_data_ok) state_next = ARB_IDLE;
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  // State, owner and last registers. The owner is captured on the grant
  // cycle; last is updated only when a transaction completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ARB_IDLE;
      owner <= M_INST;
      last  <= M_INST;
    end else begin
      state <= state_next;
      if ((state == ARB_IDLE) && any_req) owner <= pick;
      if ((state == ARB_DATA) && mem_data_ok) last <= owner;
    end
  end

  // While reset is held the FSM sits in IDLE, so the request and handshakes
  // are additionally masked to keep them quiet even with masters requesting.
  assign mem_req            = req_c & rst;
  assign cache_inst_addr_ok = addr_ok_c & rst & (sel == M_INST);
  assign cache_data_addr_ok = addr_ok_c & rst & (sel == M_DATA);
  assign cache_inst_data_ok = data_ok_c & rst & (sel == M_INST);
  assign cache_data_data_ok = data_ok_c & rst & (sel == M_DATA);

  assign mem_wr    = sel ? cache_data_wr    : cache_inst_wr;
  assign mem_size  = sel ? cache_data_size  : cache_inst_size;
  assign mem_addr  = sel ? cache_data_addr  : cache_inst_addr;
  assign mem_wdata = sel ? cache_data_wdata : cache_inst_wdata;

  assign cache_inst_rdata = mem_rdata;
  assign cache_data_rdata = mem_rdata;

endmodule

// File: tb/tb_cache_bus_arb.sv
// tb_cache_bus_arb
// Drives directed vectors into two arbiters sharing the same stimulus,
// index 0 built with FAIR=1 and index 1 with FAIR=0. A transaction-level
// model checks every output each cycle; literal expectations pin key cycles.
module tb_cache_bus_arb;
  import cache_bus_arb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic        inst_req = 0, inst_wr = 0;
  logic [1:0]  inst_size = 0;
  logic [31:0] inst_addr = 0, inst_wdata = 0;
  logic        data_req = 0, data_wr = 0;
  logic [1:0]  data_size = 0;
  logic [31:0] data_addr = 0, data_wdata = 0;
  logic [31:0] mem_rdata = 0;
  logic        mem_addr_ok = 0, mem_data_ok = 0;

  logic        p_inst_wr = 0, p_data_wr = 0;
  logic [1:0]  p_inst_size = 0, p_data_size = 0;
  logic [31:0] p_inst_addr = 0, p_inst_wdata = 0, p_data_addr = 0, p_data_wdata = 0;

  logic [31:0] o_inst_rdata [2];
  logic        o_inst_addr_ok [2];
  logic        o_inst_data_ok [2];
  logic [31:0] o_data_rdata [2];
  logic        o_data_addr_ok [2];
  logic        o_data_data_ok [2];
  logic        o_mem_req [2];
  logic        o_mem_wr [2];
  logic [1:0]  o_mem_size [2];
  logic [31:0] o_mem_addr [2];
  logic [31:0] o_mem_wdata [2];

  int passed = 0;
  int total  = 0;

  int   phase [2];
  logic own [2];
  logic lst [2];
  int   glog_fair[$];
  int   glog_fixed[$];

  always #5 clk = ~clk;

  cache_bus_arb #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .FAIR(1'b1)) dut_fair (
    .clk(clk), .rst(rst),
    .cache_inst_req(inst_req), .cache_inst_wr(inst_wr), .cache_inst_size(inst_size),
    .cache_inst_addr(inst_addr), .cache_inst_wdata(inst_wdata),
    .cache_inst_rdata(o_inst_rdata[0]), .cache_inst_addr_ok(o_inst_addr_ok[0]),
    .cache_inst_data_ok(o_inst_data_ok[0]),
    .cache_data_req(data_req), .cache_data_wr(data_wr), .cache_data_size(data_size),
    .cache_data_addr(data_addr), .cache_data_wdata(data_wdata),
    .cache_data_rdata(o_data_rdata[0]), .cache_data_addr_ok(o_data_addr_ok[0]),
    .cache_data_data_ok(o_data_data_ok[0]),
    .mem_req(o_mem_req[0]), .mem_wr(o_mem_wr[0]), .mem_size(o_mem_size[0]),
    .mem_addr(o_mem_addr[0]), .mem_wdata(o_mem_wdata[0]), .mem_rdata(mem_rdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok)
  );

  cache_bus_arb #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .FAIR(1'b0)) dut_fixed (
    .clk(clk), .rst(rst),
    .cache_inst_req(inst_req), .cache_inst_wr(inst_wr), .cache_inst_size(inst_size),
    .cache_inst_addr(inst_addr), .cache_inst_wdata(inst_wdata),
    .cache_inst_rdata(o_inst_rdata[1]), .cache_inst_addr_ok(o_inst_addr_ok[1]),
    .cache_inst_data_ok(o_inst_data_ok[1]),
    .cache_data_req(data_req), .cache_data_wr(data_wr), .cache_data_size(data_size),
    .cache_data_addr(data_addr), .cache_data_wdata(data_wdata),
    .cache_data_rdata(o_data_rdata[1]), .cache_data_addr_ok(o_data_addr_ok[1]),
    .cache_data_data_ok(o_data_data_ok[1]),
    .mem_req(o_mem_req[1]), .mem_wr(o_mem_wr[1]), .mem_size(o_mem_size[1]),
    .mem_addr(o_mem_addr[1]), .mem_wdata(o_mem_wdata[1]), .mem_rdata(mem_rdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic setInst(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata);
    p_inst_wr = wr; p_inst_size = size; p_inst_addr = addr; p_inst_wdata = wdata;
  endtask

  task automatic setData(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata);
    p_data_wr = wr; p_data_size = size; p_data_addr = addr; p_data_wdata = wdata;
  endtask

  // Inputs change just after the rising edge and are observed at the falling edge.
  task automatic applyStimulus(input logic rst_v, input logic ireq, input logic dreq,
                               input logic aok, input logic dok, input logic [31:0] rdata);
    @(posedge clk);
    #1;
    rst = rst_v;
    inst_req = ireq; inst_wr = p_inst_wr; inst_size = p_inst_size;
    inst_addr = p_inst_addr; inst_wdata = p_inst_wdata;
    data_req = dreq; data_wr = p_data_wr; data_size = p_data_size;
    data_addr = p_data_addr; data_wdata = p_data_wdata;
    mem_addr_ok = aok; mem_data_ok = dok; mem_rdata = rdata;
    @(negedge clk);
  endtask

  // Transaction view: a bus that is free, holding a granted address, or
  // waiting for read/write completion, per arbiter instance.
  task automatic modelStep(input int k);
    logic       g;
    logic       e_req, e_iaok, e_daok, e_idok, e_ddok, fields_valid;
    string      tag;
    tag = (k == 0) ? "fair" : "fixed";
    if (!rst) begin
      checkOutput({tag, " rst mem_req"}, 32'(o_mem_req[k]), 0);
      checkOutput({tag, " rst inst_addr_ok"}, 32'(o_inst_addr_ok[k]), 0);
      checkOutput({tag, " rst data_addr_ok"}, 32'(o_data_addr_ok[k]), 0);
      checkOutput({tag, " rst inst_data_ok"}, 32'(o_inst_data_ok[k]), 0);
      checkOutput({tag, " rst data_data_ok"}, 32'(o_data_data_ok[k]), 0);
      phase[k] = 0; own[k] = M_INST; lst[k] = M_INST;
      return;
    end
    g = own[k];
    e_req = 0; e_iaok = 0; e_daok = 0; e_idok = 0; e_ddok = 0; fields_valid = 1;
    if (phase[k] == 0) begin
      if (inst_req || data_req) begin
        if (inst_req && data_req) g = (k == 0) ? ~lst[k] : M_DATA;
        else g = data_req;
        e_req = 1;
        if (g) e_daok = mem_addr_ok; else e_iaok = mem_addr_ok;
      end else begin
        fields_valid = 0;
      end
    end else if (phase[k] == 1) begin
      e_req = g ? data_req : inst_req;
      if (g) e_daok = mem_addr_ok; else e_iaok = mem_addr_ok;
    end else begin
      if (g) e_ddok = mem_data_ok; else e_idok = mem_data_ok;
    end

    checkOutput({tag, " mem_req"}, 32'(o_mem_req[k]), 32'(e_req));
    checkOutput({tag, " inst_addr_ok"}, 32'(o_inst_addr_ok[k]), 32'(e_iaok));
    checkOutput({tag, " data_addr_ok"}, 32'(o_data_addr_ok[k]), 32'(e_daok));
    checkOutput({tag, " inst_data_ok"}, 32'(o_inst_data_ok[k]), 32'(e_idok));
    checkOutput({tag, " data_data_ok"}, 32'(o_data_data_ok[k]), 32'(e_ddok));
    checkOutput({tag, " inst_rdata"}, o_inst_rdata[k], mem_rdata);
    checkOutput({tag, " data_rdata"}, o_data_rdata[k], mem_rdata);
    if (fields_valid) begin
      checkOutput({tag, " mem_wr"}, 32'(o_mem_wr[k]), 32'(g ? data_wr : inst_wr));
      checkOutput({tag, " mem_size"}, 32'(o_mem_size[k]), 32'(g ? data_size : inst_size));
      checkOutput({tag, " mem_addr"}, o_mem_addr[k], g ? data_addr : inst_addr);
      checkOutput({tag, " mem_wdata"}, o_mem_wdata[k], g ? data_wdata : inst_wdata);
    end

    if (o_inst_addr_ok[k]) begin
      if (k == 0) glog_fair.push_back(0); else glog_fixed.push_back(0);
    end
    if (o_data_addr_ok[k]) begin
      if (k == 0) glog_fair.push_back(1); else glog_fixed.push_back(1);
    end

    if (phase[k] == 0) begin
      if (inst_req || data_req) begin
        own[k]   = g;
        phase[k] = mem_addr_ok ? 2 : 1;
      end
    end else if (phase[k] == 1) begin
      if (mem_addr_ok) phase[k] = 2;
    end else if (mem_data_ok) begin
      lst[k]   = own[k];
      phase[k] = 0;
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) modelStep(k);
  end

  initial begin
    int exp_fair [4];
    exp_fair = '{1, 0, 1, 0};

    // Reset held with both masters requesting and the bridge answering.
    setInst(0, SZ_WORD, 32'h0000_1000, 0);
    setData(0, SZ_WORD, 32'h0000_2000, 32'h1111_1111);
    repeat (3) begin
      applyStimulus(0, 1, 1, 1, 1, 32'h0);
      checkOutput("reset mem_req", 32'(o_mem_req[0]), 0);
      checkOutput("reset data_addr_ok", 32'(o_data_addr_ok[0]), 0);
    end

    // First contention after reset goes to data.
    applyStimulus(1, 1, 1, 1, 0, 0);
    for (int k = 0; k < 2; k++) begin
      checkOutput("first grant data_addr_ok", 32'(o_data_addr_ok[k]), 1);
      checkOutput("first grant inst_addr_ok", 32'(o_inst_addr_ok[k]), 0);
      checkOutput("first grant mem_addr", o_mem_addr[k], 32'h0000_2000);
    end
    applyStimulus(1, 0, 0, 0, 1, 32'hCAFE_F00D);
    checkOutput("first data_data_ok", 32'(o_data_data_ok[0]), 1);
    checkOutput("first data_rdata", o_data_rdata[0], 32'hCAFE_F00D);
    applyStimulus(1, 0, 0, 0, 0, 0);

    // Single instruction read with zero-cycle address acceptance.
    setInst(0, SZ_WORD, 32'hBFC0_0000, 0);
    applyStimulus(1, 1, 0, 1, 0, 0);
    for (int k = 0; k < 2; k++) begin
      checkOutput("inst read addr_ok", 32'(o_inst_addr_ok[k]), 1);
      checkOutput("inst read mem_addr", o_mem_addr[k], 32'hBFC0_0000);
    end
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 1, 32'h2408_0001);
    for (int k = 0; k < 2; k++) begin
      checkOutput("inst read data_ok", 32'(o_inst_data_ok[k]), 1);
      checkOutput("inst read rdata", o_inst_rdata[k], 32'h2408_0001);
      checkOutput("inst read data side quiet", 32'(o_data_data_ok[k]), 0);
    end
    applyStimulus(1, 0, 0, 0, 0, 0);

    // Continuous contention: fair alternates, fixed keeps picking data.
    glog_fair.delete();
    glog_fixed.delete();
    setInst(0, SZ_WORD, 32'hBFC0_0010, 0);
    setData(0, SZ_HALF, 32'h8000_0020, 0);
    repeat (8) applyStimulus(1, 1, 1, 1, 1, 32'h0000_0055);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("fair grant count", glog_fair.size(), 4);
    for (int i = 0; i < glog_fair.size() && i < 4; i++)
      checkOutput($sformatf("fair grant %0d", i), glog_fair[i], exp_fair[i]);
    checkOutput("fixed grant count", glog_fixed.size(), 4);
    for (int i = 0; i < glog_fixed.size() && i < 4; i++)
      checkOutput($sformatf("fixed grant %0d", i), glog_fixed[i], 1);

    // Data write stalled in the address phase while inst starts requesting.
    setData(1, SZ_WORD, 32'h8000_1000, 32'hDEAD_BEEF);
    setInst(0, SZ_WORD, 32'hBFC0_0020, 0);
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1, (c != 0), 1, 0, 0, 0);
      for (int k = 0; k < 2; k++) begin
        checkOutput("stall mem_req", 32'(o_mem_req[k]), 1);
        checkOutput("stall mem_addr", o_mem_addr[k], 32'h8000_1000);
        checkOutput("stall mem_wdata", o_mem_wdata[k], 32'hDEAD_BEEF);
        checkOutput("stall mem_wr", 32'(o_mem_wr[k]), 1);
      end
    end
    applyStimulus(1, 1, 1, 1, 0, 0);
    for (int k = 0; k < 2; k++) begin
      checkOutput("stall release data_addr_ok", 32'(o_data_addr_ok[k]), 1);
      checkOutput("stall release inst_addr_ok", 32'(o_inst_addr_ok[k]), 0);
    end
    applyStimulus(1, 1, 0, 1, 1, 0);
    for (int k = 0; k < 2; k++) begin
      checkOutput("stall data_data_ok", 32'(o_data_data_ok[k]), 1);
      checkOutput("stall no grant on data_ok", 32'(o_inst_addr_ok[k]), 0);
    end
    applyStimulus(1, 1, 0, 1, 0, 0);
    for (int k = 0; k < 2; k++) begin
      checkOutput("inst after stall addr_ok", 32'(o_inst_addr_ok[k]), 1);
      checkOutput("inst after stall mem_addr", o_mem_addr[k], 32'hBFC0_0020);
    end
    applyStimulus(1, 0, 0, 0, 1, 32'h3C1D_0000);
    checkOutput("inst after stall data_ok", 32'(o_inst_data_ok[0]), 1);
    applyStimulus(1, 0, 0, 0, 0, 0);

    // Reset while a read is in its data phase; the late response is dropped.
    setInst(0, SZ_WORD, 32'hBFC0_0030, 0);
    applyStimulus(1, 1, 0, 1, 0, 0);
    checkOutput("midrst grant", 32'(o_inst_addr_ok[0]), 1);
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 32'h1234_5678);
    for (int k = 0; k < 2; k++)
      checkOutput("midrst no data_ok in reset", 32'(o_inst_data_ok[k]), 0);
    applyStimulus(1, 0, 0, 0, 1, 32'h1234_5678);
    for (int k = 0; k < 2; k++)
      checkOutput("midrst stale data_ok dropped", 32'(o_inst_data_ok[k]), 0);
    setData(0, SZ_BYTE, 32'h8000_2003, 0);
    applyStimulus(1, 0, 1, 1, 0, 0);
    checkOutput("midrst new grant", 32'(o_data_addr_ok[0]), 1);
    applyStimulus(1, 0, 0, 0, 1, 32'h0000_00A5);
    checkOutput("midrst new data_ok", 32'(o_data_data_ok[0]), 1);
    checkOutput("midrst new rdata", o_data_rdata[0], 32'h0000_00A5);
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
